// File: rtl/mem_io_bus_arbiter.sv
// mem_io_bus_arbiter: arbitrates CPU and UART loader onto the data RAM and memory-mapped IO
module mem_io_bus_arbiter #(
    parameter int          ADDR_W     = 14,
    parameter int          MEM_RD_LAT = 1,
    parameter logic [21:0] IO_HI      = 22'h3FFFFF,
    parameter logic [31:0] LED_ADDR   = 32'hFFFFFC60,
    parameter logic [31:0] SW_ADDR    = 32'hFFFFFC70
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    input  logic              ldr_req,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              led_cs,
    output logic [15:0]       led_wdata,
    output logic              sw_cs,
    input  logic [15:0]       sw_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic owner, we_q, prio, grant_ldr, is_io, is_led, is_sw;
    logic [31:0] addr_q, wdata_q;
    logic [2:0] cnt;
    assign grant_ldr = ldr_req && (!cpu_req || prio);
    assign is_io     = addr_q[31:10] == IO_HI;
    assign is_led    = is_io && !owner && we_q && addr_q == LED_ADDR;
    assign is_sw     = is_io && !owner && !we_q && addr_q == SW_ADDR;
    assign cpu_stall = cpu_req && !(state == RESP && !owner);
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // next state and strobes; strobes only ever leave zero in ISSUE
    always_comb begin
        state_nx  = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        led_cs    = 1'b0;
        led_wdata = '0;
        sw_cs     = 1'b0;
        cpu_done  = 1'b0;
        ldr_ack   = 1'b0;
        case (state)
            IDLE: state_nx = (cpu_req || ldr_req) ? ISSUE : IDLE;
            ISSUE: begin
                mem_en    = !is_io;
                mem_we    = !is_io && we_q;
                mem_addr  = addr_q[ADDR_W+1:2];
                mem_wdata = wdata_q;
                led_cs    = is_led;
                led_wdata = wdata_q[15:0];
                sw_cs     = is_sw;
                state_nx  = (!is_io && !we_q) ? WAIT : RESP;
            end
            WAIT: state_nx = (cnt == 3'd0) ? RESP : WAIT;
            default: begin
                cpu_done = !owner;
                ldr_ack  = owner;
                state_nx = IDLE;
            end
        endcase
    end
    // grant latch, round-robin priority, read-latency counter and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            prio      <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            if (state == IDLE && (cpu_req || ldr_req)) begin
                owner   <= grant_ldr;
                we_q    <= grant_ldr || cpu_we;
                addr_q  <= grant_ldr ? ldr_addr : cpu_addr;
                wdata_q <= grant_ldr ? ldr_wdata : cpu_wdata;
                prio    <= !grant_ldr;
            end
            if (state == ISSUE) begin
                cnt <= 3'(MEM_RD_LAT - 1);
                if (is_io && !we_q && !owner) cpu_rdata <= is_sw ? {16'h0, sw_rdata} : 32'h0;
            end
            if (state == WAIT) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd0 && !owner) cpu_rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_bus_arbiter.sv
// tb_mem_io_bus_arbiter: random CPU/loader traffic checked against a transaction-level model
module tb_mem_io_bus_arbiter;
    localparam int LAT = 3;
    localparam logic [31:0] LED = 32'hFFFFFC60;
    localparam logic [31:0] SW  = 32'hFFFFFC70;
    typedef struct packed {logic ldr; logic we; logic [31:0] addr; logic [31:0] wdata;} op_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, ldr_addr = '0, ldr_wdata = '0;
    logic [15:0] sw_rdata = '0;
    logic [31:0] cpu_rdata, mem_wdata, mem_rdata;
    logic cpu_stall, cpu_done, ldr_ack, mem_en, mem_we, led_cs, sw_cs;
    logic [13:0] mem_addr;
    logic [15:0] led_wdata;
    mem_io_bus_arbiter #(.MEM_RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .led_cs(led_cs), .led_wdata(led_wdata), .sw_cs(sw_cs),
        .sw_rdata(sw_rdata)
    );
    always #5 clk = ~clk;
    // synchronous RAM with LAT-cycle read latency
    bit [31:0] ram [0:16383];
    bit [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 32'h0BAD0BAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];
    int n_chk = 0, n_pass = 0, cyc = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask
    // transaction-level reference: one access at a time, 3 cycles or 3+LAT for memory reads
    bit [31:0] mmem [0:16383];
    op_t cur;
    bit busy = 0, prio = 0, c_saw = 0, l_saw = 0;
    int g_cyc = 0, d_cyc = 0, c_left = 60, l_left = 40;
    logic [31:0] exp_rdata = '0, rd_val = '0;
    op_t cq[$], lq[$];
    task automatic sample();
        bit pick, io, iss, e_men, e_led, e_sw, e_done, e_ack;
        cyc++;
        if (!rst_n) begin
            busy = 0; prio = 0; exp_rdata = '0;
        end else if (!busy || cyc > d_cyc) begin
            busy = 0;
            if (cpu_req || ldr_req) begin
                pick = (cpu_req && ldr_req) ? prio : ldr_req;
                cur = pick ? op_t'{1'b1, 1'b1, ldr_addr, ldr_wdata} : op_t'{1'b0, cpu_we, cpu_addr, cpu_wdata};
                prio = !pick; busy = 1; g_cyc = cyc;
                d_cyc = cyc + 2 + ((cur.addr[31:10] != 22'h3FFFFF && !cur.we) ? LAT : 0);
            end
        end
        io = cur.addr[31:10] == 22'h3FFFFF;
        iss = busy && cyc == g_cyc + 1;
        e_men = iss && !io;
        e_led = iss && io && !cur.ldr && cur.we && cur.addr == LED;
        e_sw = iss && io && !cur.ldr && !cur.we && cur.addr == SW;
        if (iss) begin
            if (!io && cur.we) mmem[cur.addr[15:2]] = cur.wdata;
            rd_val = !io ? mmem[cur.addr[15:2]] : e_sw ? {16'h0, sw_rdata} : 32'h0;
        end
        e_done = busy && cyc == d_cyc && !cur.ldr;
        e_ack = busy && cyc == d_cyc && cur.ldr;
        if (e_done && !cur.we) exp_rdata = rd_val;
        chk("cpu_done", 32'(cpu_done), 32'(e_done));
        chk("ldr_ack", 32'(ldr_ack), 32'(e_ack));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_done));
        chk("mem_en", 32'(mem_en), 32'(e_men));
        chk("led_cs", 32'(led_cs), 32'(e_led));
        chk("sw_cs", 32'(sw_cs), 32'(e_sw));
        chk("cpu_rdata", cpu_rdata, exp_rdata);
        if (e_men) begin
            chk("mem_we", 32'(mem_we), 32'(cur.we));
            chk("mem_addr", 32'(mem_addr), 32'(cur.addr[15:2]));
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        end
        if (e_led) chk("led_wdata", 32'(led_wdata), 32'(cur.wdata[15:0]));
        c_saw = cpu_done;
        l_saw = ldr_ack;
    endtask
    function automatic op_t rnd_op(input bit ldr);
        op_t o;
        int k = $urandom_range(0, 9);
        o.ldr = ldr;
        o.we = ldr ? 1'b1 : 1'($urandom_range(0, 1));
        o.wdata = $urandom;
        o.addr = k < 7 ? (($urandom & 32'h7FFF0000) | (32'($urandom_range(0, 31)) << 2)) :
                 k == 7 ? LED : k == 8 ? SW : (32'hFFFFFC00 | (32'($urandom_range(0, 255)) << 2));
        return o;
    endfunction
    task automatic new_cpu();
        op_t o = cq.size() ? cq.pop_front() : rnd_op(1'b0);
        cpu_req = 1; cpu_we = o.we; cpu_addr = o.addr; cpu_wdata = o.wdata; c_left--;
    endtask
    task automatic new_ldr();
        op_t o = lq.size() ? lq.pop_front() : rnd_op(1'b1);
        ldr_req = 1; ldr_addr = o.addr; ldr_wdata = o.wdata; l_left--;
    endtask
    task automatic drive();
        sw_rdata = $urandom_range(0, 3) == 0 ? 16'h8001 : 16'($urandom);
        if (cpu_req && c_saw) begin
            if (c_left > 0 && $urandom_range(0, 1) == 1) new_cpu();
            else cpu_req = 0;
        end else if (!cpu_req && c_left > 0 && $urandom_range(0, 2) == 0) new_cpu();
        if (ldr_req && l_saw) begin
            if (l_left > 0 && $urandom_range(0, 1) == 1) new_ldr();
            else ldr_req = 0;
        end else if (!ldr_req && l_left > 0 && $urandom_range(0, 2) == 0) new_ldr();
    endtask
    int rc, done_c;
    initial begin
        cq.push_back(op_t'{1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF});
        cq.push_back(op_t'{1'b0, 1'b0, 32'h00000010, 32'h0});
        cq.push_back(op_t'{1'b0, 1'b1, LED, 32'h0001A5A5});
        cq.push_back(op_t'{1'b0, 1'b0, SW, 32'h0});
        lq.push_back(op_t'{1'b1, 1'b1, 32'h00000100, 32'h11112222});
        lq.push_back(op_t'{1'b1, 1'b1, LED, 32'h00001234});
        repeat (3) begin @(negedge clk); sample(); end
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_led_wdata", 32'(led_wdata), 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk); sample();
        @(posedge clk); #1; new_cpu(); new_ldr();
        @(negedge clk); sample();
        for (int k = 0; k < 4000 && (c_left > 0 || l_left > 0 || cpu_req || ldr_req || busy); k++) begin
            @(posedge clk); #1; drive();
            @(negedge clk); sample();
        end
        chk("drain", 32'(cpu_req || ldr_req), 0);
        @(posedge clk); #1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h00000010;
        @(negedge clk); sample();
        repeat (2) begin @(posedge clk); #1; @(negedge clk); sample(); end
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk); sample();
        chk("midrst_rdata", cpu_rdata, 0);
        @(posedge clk); #1 rst_n = 1; rc = cyc + 1;
        @(negedge clk); sample();
        done_c = -1;
        for (int k = 0; k < 20; k++) begin
            if (cpu_done) begin done_c = cyc; break; end
            @(posedge clk); #1; @(negedge clk); sample();
        end
        chk("rst_lat", 32'(done_c - rc + 1), 6);
        @(posedge clk); #1 cpu_req = 0;
        repeat (3) begin @(negedge clk); sample(); @(posedge clk); #1; end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
